// File: rtl/branch_predict_resolve_pkg.sv
// -----------------------------------------------------------------------------
// branch_predict_resolve_pkg
// Shared definitions for the branch unit:
//   - 3-bit branch condition op codes (also used by the control unit)
//   - br_cond(): resolves a MIPS branch condition from the ALU flags
// -----------------------------------------------------------------------------
package branch_predict_resolve_pkg;

    typedef logic [2:0] br_op_t;

    localparam br_op_t BR_BEQ    = 3'd0;  // taken when Zero
    localparam br_op_t BR_BNE    = 3'd1;  // taken when !Zero
    localparam br_op_t BR_BGTZ   = 3'd2;  // taken when !Zero & !Sign
    localparam br_op_t BR_BLEZ   = 3'd3;  // taken when Zero | Sign
    localparam br_op_t BR_REGIMM = 3'd4;  // rt[0]=1 BGEZ, rt[0]=0 BLTZ
    localparam br_op_t BR_ALWAYS = 3'd5;  // jumps
    localparam br_op_t BR_NEVER  = 3'd6;  // 6 and 7 never take

    // Condition decode; unused op codes resolve to not-taken.
    function automatic logic br_cond(input br_op_t op,
                                     input logic   zero,
                                     input logic   sign,
                                     input logic   rt);
        logic taken;
        taken = 1'b0;
        case (op)
            BR_BEQ:    taken = zero;
            BR_BNE:    taken = !zero;
            BR_BGTZ:   taken = !zero && !sign;
            BR_BLEZ:   taken = zero || sign;
            BR_REGIMM: taken = rt ? !sign : sign;
            BR_ALWAYS: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/branch_predict_resolve_sat_counter.sv
// -----------------------------------------------------------------------------
// branch_predict_resolve_sat_counter
// One W-bit saturating up/down counter (a single BHT entry).
// Ports:
//   Clk   in   rising-edge clock
//   Rst   in   synchronous active-high reset, loads init
//   init  in   W   reset value
//   en    in   count enable
//   up    in   1 = increment, 0 = decrement (when en)
//   q     out  W   current count
// -----------------------------------------------------------------------------
module branch_predict_resolve_sat_counter #(
    parameter int W = 2
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic [W-1:0] init,
    input  logic         en,
    input  logic         up,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] q_reg;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            q_reg <= init;
        end else if (en) begin
            if (up) begin
                if (q_reg != '1) q_reg <= q_reg + ONE;
            end else begin
                if (q_reg != '0) q_reg <= q_reg - ONE;
            end
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/branch_predict_resolve.sv
// -----------------------------------------------------------------------------
// branch_predict_resolve
// Branch unit: resolves MIPS branch conditions in EX, predicts in IF from a
// direct-mapped, tag-less table of saturating counters, flags mispredicts and
// keeps saturating branch / mispredict statistics.
// Ports:
//   Clk, Rst            clock, synchronous active-high reset
//   IF_PC               fetch PC; IF_PredTaken = MSB of its counter (comb)
//   EX_Branch           EX holds a branch/jump
//   EX_PC               PC of the EX instruction (selects counter to train)
//   EX_BranchLogicOp    condition select (see package op codes)
//   EX_Zero/SignBit/Rt  ALU flags and rt[0] for REGIMM
//   EX_PredTaken        prediction carried with the EX instruction
//   EX_Stall            EX frozen: no training, no statistics
//   EX_Taken            resolved outcome (comb, 0 when no branch)
//   EX_Mispredict       resolved outcome differs from prediction (comb)
//   BranchCount         resolved branches (registered, saturating)
//   MispredictCount     mispredicts (registered, saturating)
// -----------------------------------------------------------------------------
module branch_predict_resolve
    import branch_predict_resolve_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int CTR_BITS   = 2,
    parameter int INIT_CTR   = 1,
    parameter int STAT_BITS  = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [31:0]          IF_PC,
    output logic                 IF_PredTaken,
    input  logic                 EX_Branch,
    input  logic [31:0]          EX_PC,
    input  logic [2:0]           EX_BranchLogicOp,
    input  logic                 EX_Zero,
    input  logic                 EX_SignBit,
    input  logic                 EX_Rt,
    input  logic                 EX_PredTaken,
    input  logic                 EX_Stall,
    output logic                 EX_Taken,
    output logic                 EX_Mispredict,
    output logic [STAT_BITS-1:0] BranchCount,
    output logic [STAT_BITS-1:0] MispredictCount
);

    localparam int                    DEPTH    = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0]   INIT_VAL = CTR_BITS'(INIT_CTR);
    localparam logic [STAT_BITS-1:0]  STAT_ONE = STAT_BITS'(1);

    // Word-aligned index; byte offset and high PC bits are deliberately
    // dropped, so aliasing PCs share an entry.
    logic [INDEX_BITS-1:0] if_idx;
    logic [INDEX_BITS-1:0] ex_idx;
    assign if_idx = IF_PC[INDEX_BITS+1:2];
    assign ex_idx = EX_PC[INDEX_BITS+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{IF_PC[31:INDEX_BITS+2], IF_PC[1:0],
                              EX_PC[31:INDEX_BITS+2], EX_PC[1:0]};

    // Resolution
    logic upd;
    assign EX_Taken      = EX_Branch && br_cond(EX_BranchLogicOp, EX_Zero,
                                                EX_SignBit, EX_Rt);
    assign EX_Mispredict = EX_Branch && (EX_Taken != EX_PredTaken);
    assign upd           = EX_Branch && !EX_Stall;

    // Branch history table
    logic [CTR_BITS-1:0] ctr_q [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bht
            branch_predict_resolve_sat_counter #(
                .W(CTR_BITS)
            ) u_ctr (
                .Clk  (Clk),
                .Rst  (Rst),
                .init (INIT_VAL),
                .en   (upd && (ex_idx == INDEX_BITS'(gi))),
                .up   (EX_Taken),
                .q    (ctr_q[gi])
            );
        end
    endgenerate

    // Combinational read of the registered counters: a same-cycle write to
    // the same entry is only visible after the edge (read-before-write).
    logic [CTR_BITS-1:0] if_ctr;
    assign if_ctr       = ctr_q[if_idx];
    assign IF_PredTaken = if_ctr[CTR_BITS-1];

    // Statistics
    logic [STAT_BITS-1:0] branch_count_reg;
    logic [STAT_BITS-1:0] mispredict_count_reg;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            branch_count_reg     <= '0;
            mispredict_count_reg <= '0;
        end else if (upd) begin
            if (branch_count_reg != '1)
                branch_count_reg <= branch_count_reg + STAT_ONE;
            if (EX_Mispredict && (mispredict_count_reg != '1))
                mispredict_count_reg <= mispredict_count_reg + STAT_ONE;
        end
    end

    assign BranchCount     = branch_count_reg;
    assign MispredictCount = mispredict_count_reg;

endmodule

// File: tb/tb_branch_predict_resolve.sv
module tb_branch_predict_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_pred;
    logic        ex_branch;
    logic [31:0] ex_pc;
    logic [2:0]  ex_op;
    logic        ex_zero, ex_sign, ex_rt, ex_pred, ex_stall;
    logic        ex_taken, ex_mispred;
    logic [31:0] branch_count, mispred_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_predict_resolve dut (
        .Clk              (clk),
        .Rst              (rst),
        .IF_PC            (if_pc),
        .IF_PredTaken     (if_pred),
        .EX_Branch        (ex_branch),
        .EX_PC            (ex_pc),
        .EX_BranchLogicOp (ex_op),
        .EX_Zero          (ex_zero),
        .EX_SignBit       (ex_sign),
        .EX_Rt            (ex_rt),
        .EX_PredTaken     (ex_pred),
        .EX_Stall         (ex_stall),
        .EX_Taken         (ex_taken),
        .EX_Mispredict    (ex_mispred),
        .BranchCount      (branch_count),
        .MispredictCount  (mispred_count)
    );

    // ---------------- reference model ----------------
    int     m_bht [64];
    longint m_bc, m_mc;

    function automatic bit m_cond(int op, bit z, bit s, bit rt);
        if (op == 0) return z;
        if (op == 1) return !z;
        if (op == 2) return !z && !s;
        if (op == 3) return z || s;
        if (op == 4) return rt ? !s : s;
        if (op == 5) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_idx(logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic bit m_pred(logic [31:0] pc);
        return m_bht[m_idx(pc)] >= 2;
    endfunction

    // Advance one clock; the model takes the same edge using pre-edge inputs.
    task automatic tick();
        bit tk;
        int i;
        tk = ex_branch && m_cond(int'(ex_op), ex_zero, ex_sign, ex_rt);
        if (rst) begin
            foreach (m_bht[k]) m_bht[k] = 1;
            m_bc = 0;
            m_mc = 0;
        end else if (ex_branch && !ex_stall) begin
            i = m_idx(ex_pc);
            m_bht[i] = tk ? ((m_bht[i] + 1 > 3) ? 3 : m_bht[i] + 1)
                          : ((m_bht[i] - 1 < 0) ? 0 : m_bht[i] - 1);
            if (m_bc < 64'hFFFF_FFFF) m_bc++;
            if (tk != ex_pred && m_mc < 64'hFFFF_FFFF) m_mc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, longint got, longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        ex_branch = 0; ex_stall = 0; ex_op = 0; ex_zero = 0; ex_sign = 0;
        ex_rt = 0; ex_pred = 0; ex_pc = 0; if_pc = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic set_br(logic [31:0] pc, logic [2:0] op, bit z, bit s, bit r,
                          bit pred, bit stall);
        ex_branch = 1; ex_pc = pc; ex_op = op; ex_zero = z; ex_sign = s;
        ex_rt = r; ex_pred = pred; ex_stall = stall;
    endtask

    // ---------------- decode table ----------------
    typedef struct {
        logic [2:0] op;
        bit         z;
        bit         s;
        bit         rt;
        bit         exp;
    } dec_vec_t;

    dec_vec_t dec_tab [20];

    initial begin
        dec_tab[0]  = '{3'd0, 1, 0, 0, 1};
        dec_tab[1]  = '{3'd0, 0, 1, 0, 0};
        dec_tab[2]  = '{3'd1, 1, 0, 0, 0};
        dec_tab[3]  = '{3'd1, 0, 0, 0, 1};
        dec_tab[4]  = '{3'd2, 0, 0, 0, 1};
        dec_tab[5]  = '{3'd2, 0, 1, 0, 0};
        dec_tab[6]  = '{3'd2, 1, 0, 0, 0};
        dec_tab[7]  = '{3'd3, 0, 0, 0, 0};
        dec_tab[8]  = '{3'd3, 0, 1, 0, 1};
        dec_tab[9]  = '{3'd3, 1, 0, 0, 1};
        dec_tab[10] = '{3'd4, 0, 0, 1, 1};
        dec_tab[11] = '{3'd4, 0, 1, 1, 0};
        dec_tab[12] = '{3'd4, 0, 1, 0, 1};
        dec_tab[13] = '{3'd4, 0, 0, 0, 0};
        dec_tab[14] = '{3'd5, 0, 0, 0, 1};
        dec_tab[15] = '{3'd5, 1, 1, 1, 1};
        dec_tab[16] = '{3'd6, 1, 0, 0, 0};
        dec_tab[17] = '{3'd6, 0, 1, 1, 0};
        dec_tab[18] = '{3'd7, 1, 1, 1, 0};
        dec_tab[19] = '{3'd7, 0, 0, 0, 0};

        rst = 1;
        idle_inputs();
        foreach (m_bht[k]) m_bht[k] = 1;
        m_bc = 0;
        m_mc = 0;
        @(posedge clk);
        #1;

        // 1: reset state
        do_reset();
        for (int pc = 0; pc <= 'hFC; pc += 4) begin
            if_pc = pc;
            #1;
            if (if_pred !== 1'b0) begin
                errors++;
                $display("FAIL reset_pred pc=%h: got %0b expected 0", pc, if_pred);
            end
            checks++;
        end
        check("reset_branch_count", branch_count, 0);
        check("reset_mispred_count", mispred_count, 0);

        // 2: decode table and full sweep (stalled, so no state change)
        foreach (dec_tab[i]) begin
            set_br(32'h0, dec_tab[i].op, dec_tab[i].z, dec_tab[i].s, dec_tab[i].rt, 0, 1);
            #1;
            if (ex_taken !== dec_tab[i].exp) begin
                errors++;
                $display("FAIL dec_tab[%0d] op=%0d z=%0b s=%0b rt=%0b: got %0b expected %0b",
                         i, dec_tab[i].op, dec_tab[i].z, dec_tab[i].s, dec_tab[i].rt,
                         ex_taken, dec_tab[i].exp);
            end
            checks++;
        end
        for (int op = 0; op < 8; op++) begin
            for (int f = 0; f < 8; f++) begin
                set_br(32'h0, 3'(op), f[0], f[1], f[2], 0, 1);
                #1;
                if (ex_taken !== m_cond(op, f[0], f[1], f[2])) begin
                    errors++;
                    $display("FAIL dec_sweep op=%0d f=%0d: got %0b expected %0b",
                             op, f, ex_taken, m_cond(op, f[0], f[1], f[2]));
                end
                checks++;
            end
        end
        ex_branch = 0;
        ex_op = 3'd5;
        #1;
        check("no_branch_taken", ex_taken, 0);
        check("no_branch_mispred", ex_mispred, 0);
        ex_stall = 0;

        // 3: training PC 0x40 (counter starts at 1)
        do_reset();
        if_pc = 32'h40;
        set_br(32'h40, 3'd0, 1, 0, 0, 0, 0);
        tick();
        check("train_after_1", if_pred, 1);
        tick();
        tick(); tick(); tick();
        check("train_saturated", if_pred, 1);
        ex_zero = 0;             // BEQ not taken: 3 -> 2
        tick();
        check("train_dec_once", if_pred, 1);
        tick();                  // 2 -> 1
        check("train_dec_twice", if_pred, 0);
        tick(); tick();          // 1 -> 0 -> 0 (floor)
        ex_zero = 1;             // 0 -> 1
        tick();
        check("train_floor", if_pred, 0);
        check("train_branch_count", branch_count, 10);
        ex_branch = 0;

        // 4: mispredict
        do_reset();
        set_br(32'h80, 3'd1, 1, 0, 0, 1, 0);
        #1;
        check("mispred_taken", ex_taken, 0);
        check("mispred_flag", ex_mispred, 1);
        tick();
        ex_branch = 0;
        #1;
        check("mispred_count", mispred_count, 1);
        check("mispred_branch_count", branch_count, 1);

        // 5: stall
        if_pc = 32'h44;
        set_br(32'h44, 3'd5, 0, 0, 0, 0, 1);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall_taken_valid", ex_taken, 1);
            tick();
        end
        ex_branch = 0;
        ex_stall = 0;
        #1;
        check("stall_branch_count", branch_count, 1);
        check("stall_mispred_count", mispred_count, 1);
        check("stall_pred", if_pred, 0);

        // 6: collision and alias
        do_reset();
        if_pc = 32'h100;
        set_br(32'h100, 3'd0, 1, 0, 0, 0, 0);
        #1;
        check("collision_old_value", if_pred, 0);
        tick();
        ex_branch = 0;
        #1;
        check("collision_after", if_pred, 1);
        do_reset();
        set_br(32'h200, 3'd5, 0, 0, 0, 0, 0);
        tick();
        ex_branch = 0;
        #1;
        check("alias_pred", if_pred, 1);

        // reset overrides a pending update
        set_br(32'h100, 3'd5, 0, 0, 0, 0, 0);
        rst = 1;
        #1;
        check("reset_comb_live", ex_taken, 1);
        tick();
        rst = 0;
        ex_branch = 0;
        #1;
        check("reset_discard_pred", if_pred, 0);
        check("reset_discard_count", branch_count, 0);

        // random stimulus against the model
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 99) < 2);
            ex_branch = ($urandom_range(0, 99) < 80);
            ex_stall  = ($urandom_range(0, 99) < 20);
            ex_op     = 3'($urandom_range(0, 7));
            ex_zero   = 1'($urandom);
            ex_sign   = 1'($urandom);
            ex_rt     = 1'($urandom);
            ex_pc     = {$urandom_range(0, 3) << 8} | ($urandom_range(0, 7) << 2)
                        | $urandom_range(0, 3);
            if_pc     = {$urandom_range(0, 3) << 8} | ($urandom_range(0, 7) << 2);
            ex_pred   = ($urandom_range(0, 3) == 0) ? 1'($urandom) : m_pred(ex_pc);
            #1;
            begin
                bit tk;
                tk = ex_branch && m_cond(int'(ex_op), ex_zero, ex_sign, ex_rt);
                check("rnd_taken", ex_taken, tk);
                check("rnd_mispred", ex_mispred, ex_branch && (tk != ex_pred));
                check("rnd_if_pred", if_pred, m_pred(if_pc));
            end
            tick();
            check("rnd_branch_count", branch_count, m_bc);
            check("rnd_mispred_count", mispred_count, m_mc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
